// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the second-order sequence generator.
package seq_gen_pkg;

  localparam int DEF_W  = 13;
  localparam int DEF_NW = 6;

  typedef enum logic [1:0] {
    e_idle,
    e_calc,
    e_done
  } t_state;

endpackage

// File: rtl/seq_gen_q_sat_add.sv
// Unsigned W-bit adder that reports the carry out and optionally clamps
// the sum to all-ones when the carry is set.
module sat_add #(
  parameter int W   = 13,
  parameter int SAT = 0
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o  = full_sum[W];
  assign sum_o    = ((SAT != 0) && full_sum[W]) ? '1 : full_sum[W-1:0];

endmodule

// File: rtl/seq_gen_q.sv
// Second-order sequence generator: term n of base + n*step + inc*n(n-1)/2,
// one iteration per clock, behind a start/done/clear handshake.
module seq_gen_q
  import seq_gen_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int NW  = DEF_NW,
  parameter int SAT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic          i_abort,
  input  logic [NW-1:0] i_n,
  input  logic [W-1:0]  i_base,
  input  logic [W-1:0]  i_step,
  input  logic [W-1:0]  i_inc,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf,
  output logic [W-1:0]  o_val
);

  t_state        state_q, state_d;
  logic [NW-1:0] r_n_q, r_n_d;
  logic [W-1:0]  r_acc_q, r_acc_d;
  logic [W-1:0]  r_step_q, r_step_d;
  logic [W-1:0]  r_inc_q, r_inc_d;
  logic [W-1:0]  r_val_q, r_val_d;
  logic          r_ovf_run_q, r_ovf_run_d;
  logic          r_ovf_q, r_ovf_d;

  logic [W-1:0]  acc_sum, step_sum;
  logic          acc_carry, step_carry;
  logic          load;

  sat_add #(.W(W), .SAT(SAT)) u_acc_add (
    .a_i     (r_acc_q),
    .b_i     (r_step_q),
    .sum_o   (acc_sum),
    .carry_o (acc_carry)
  );

  sat_add #(.W(W), .SAT(SAT)) u_step_add (
    .a_i     (r_step_q),
    .b_i     (r_inc_q),
    .sum_o   (step_sum),
    .carry_o (step_carry)
  );

  // Start is honoured from both idle and done, so a finished run can chain
  // straight into the next one without a clear.
  assign load = i_start && (state_q != e_calc);

  always_comb begin
    // NOTE: every next-state signal takes its held value first so that no
    // path through the case statement leaves one unassigned (no latches).
    state_d     = state_q;
    r_n_d       = r_n_q;
    r_acc_d     = r_acc_q;
    r_step_d    = r_step_q;
    r_inc_d     = r_inc_q;
    r_val_d     = r_val_q;
    r_ovf_run_d = r_ovf_run_q;
    r_ovf_d     = r_ovf_q;

    if (load) begin
      state_d     = e_calc;
      r_n_d       = i_n;
      r_acc_d     = i_base;
      r_step_d    = i_step;
      r_inc_d     = i_inc;
      r_ovf_run_d = 1'b0;
    end else begin
      unique case (state_q)
        e_calc: begin
          if (i_abort) begin
            state_d = e_idle;
          end else if (r_n_q == '0) begin
            state_d = e_done;
            r_val_d = r_acc_q;
            r_ovf_d = r_ovf_run_q;
          end else begin
            r_acc_d     = acc_sum;
            r_step_d    = step_sum;
            r_n_d       = r_n_q - NW'(1);
            r_ovf_run_d = r_ovf_run_q | acc_carry | step_carry;
          end
        end
        e_done: begin
          if (i_clear) state_d = e_idle;
        end
        default: state_d = e_idle;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= e_idle;
      r_n_q       <= '0;
      r_acc_q     <= '0;
      r_step_q    <= '0;
      r_inc_q     <= '0;
      r_val_q     <= '0;
      r_ovf_run_q <= 1'b0;
      r_ovf_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_n_q       <= r_n_d;
      r_acc_q     <= r_acc_d;
      r_step_q    <= r_step_d;
      r_inc_q     <= r_inc_d;
      r_val_q     <= r_val_d;
      r_ovf_run_q <= r_ovf_run_d;
      r_ovf_q     <= r_ovf_d;
    end
  end

  assign o_ready = (state_q == e_idle) || (state_q == e_done);
  assign o_busy  = (state_q == e_calc);
  assign o_done  = (state_q == e_done);
  assign o_ovf   = r_ovf_q;
  assign o_val   = r_val_q;

endmodule

// File: tb/tb_seq_gen_q.sv
// Randomised and directed bench for seq_gen_q: a wrapping and a saturating
// instance share stimulus and are compared against an iterative reference.
module tb_seq_gen_q;

  localparam int W    = 13;
  localparam int NW   = 6;
  localparam int MAXV = (1 << W) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_abort = 1'b0;
  logic [NW-1:0] i_n = '0;
  logic [W-1:0]  i_base = '0;
  logic [W-1:0]  i_step = '0;
  logic [W-1:0]  i_inc = '0;

  logic          w_ready, w_busy, w_done, w_ovf;
  logic [W-1:0]  w_val;
  logic          s_ready, s_busy, s_done, s_ovf;
  logic [W-1:0]  s_val;

  seq_gen_q #(.W(W), .NW(NW), .SAT(0)) u_dut_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clear(i_clear),
    .i_abort(i_abort), .i_n(i_n), .i_base(i_base), .i_step(i_step),
    .i_inc(i_inc), .o_ready(w_ready), .o_busy(w_busy), .o_done(w_done),
    .o_ovf(w_ovf), .o_val(w_val)
  );

  seq_gen_q #(.W(W), .NW(NW), .SAT(1)) u_dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clear(i_clear),
    .i_abort(i_abort), .i_n(i_n), .i_base(i_base), .i_step(i_step),
    .i_inc(i_inc), .o_ready(s_ready), .o_busy(s_busy), .o_done(s_done),
    .o_ovf(s_ovf), .o_val(s_val)
  );

  always #5 i_clk = ~i_clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected last-completed results, carried between runs.
  int exp_wv = 0;
  bit exp_wo = 1'b0;
  int exp_sv = 0;
  bit exp_so = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: step through the series term by term with wide integers.
  function automatic void model(input int n, input int base, input int step,
                                input int inc, input bit sat,
                                output int val, output bit ovf);
    int a, s, ta, ts;
    a   = base;
    s   = step;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      ta = a + s;
      ts = s + inc;
      if (ta > MAXV) begin
        ovf = 1'b1;
        ta  = sat ? MAXV : ta - (MAXV + 1);
      end
      if (ts > MAXV) begin
        ovf = 1'b1;
        ts  = sat ? MAXV : ts - (MAXV + 1);
      end
      a = ta;
      s = ts;
    end
    val = a;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, w_ready & s_ready}, 1);
    check({tag, "_busy"},  {31'd0, w_busy | s_busy}, 0);
    check({tag, "_done"},  {31'd0, w_done | s_done}, 0);
    check({tag, "_ovf"},   {31'd0, w_ovf | s_ovf}, 0);
    check({tag, "_val"},   {19'd0, w_val | s_val}, 0);
  endtask

  task automatic run(input int n, input int base, input int step, input int inc,
                     input bit with_clear, input bit poke_start);
    int wv, sv, cnt;
    bit wo, so, busy_ok;
    model(n, base, step, inc, 1'b0, wv, wo);
    model(n, base, step, inc, 1'b1, sv, so);
    i_start = 1'b1;
    i_clear = with_clear;
    i_n     = NW'(n);
    i_base  = W'(base);
    i_step  = W'(step);
    i_inc   = W'(inc);
    tick();
    i_start = 1'b0;
    i_clear = 1'b0;
    check("busy_after_start", {31'd0, w_busy & s_busy}, 1);
    check("done_low_after_start", {31'd0, w_done | s_done}, 0);
    check("val_hold_wrap", {19'd0, w_val}, exp_wv);
    check("ovf_hold_sat", {31'd0, s_ovf}, {31'd0, exp_so});
    if (poke_start) begin
      // A start during calc must not disturb the run in progress.
      i_start = 1'b1;
      i_n     = NW'($urandom);
      i_base  = W'($urandom);
      i_step  = W'($urandom);
      i_inc   = W'($urandom);
    end
    cnt     = 0;
    busy_ok = 1'b1;
    while (!w_done && cnt <= 200) begin
      if (!w_busy || !s_busy) busy_ok = 1'b0;
      tick();
      i_start = 1'b0;
      cnt++;
    end
    check("busy_throughout", {31'd0, busy_ok}, 1);
    check("latency", cnt, n + 1);
    check("done_sat", {31'd0, s_done}, 1);
    check("val_wrap", {19'd0, w_val}, wv);
    check("ovf_wrap", {31'd0, w_ovf}, {31'd0, wo});
    check("val_sat", {19'd0, s_val}, sv);
    check("ovf_sat", {31'd0, s_ovf}, {31'd0, so});
    exp_wv = wv;
    exp_wo = wo;
    exp_sv = sv;
    exp_so = so;
  endtask

  task automatic clear_done();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("clear_ready", {31'd0, w_ready & s_ready}, 1);
    check("clear_done_low", {31'd0, w_done | s_done}, 0);
    check("clear_val_hold", {19'd0, w_val}, exp_wv);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done_seen;
    #3;
    check_reset_outputs("por");
    #4;
    i_rst = 1'b0;
    tick();

    // Directed cases from the original 5/5/+4 series and overflow corners.
    run(0, 5, 5, 4, 1'b0, 1'b0);
    clear_done();
    run(3, 5, 5, 4, 1'b0, 1'b0);
    clear_done();
    run(1, 8000, 200, 0, 1'b0, 1'b0);
    clear_done();
    run(63, 0, 1, 0, 1'b0, 1'b0);
    clear_done();
    run(3, 5, 5, 4, 1'b0, 1'b0);
    clear_done();

    // Abort on the third calc cycle: previous result must survive.
    i_start = 1'b1;
    i_n     = NW'(10);
    i_base  = W'(100);
    i_step  = W'(7);
    i_inc   = W'(3);
    tick();
    i_start   = 1'b0;
    done_seen = w_done;
    tick();
    done_seen |= w_done;
    tick();
    done_seen |= w_done;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    done_seen |= w_done;
    check("abort_done_never", {31'd0, done_seen}, 0);
    check("abort_ready", {31'd0, w_ready & s_ready}, 1);
    check("abort_busy", {31'd0, w_busy | s_busy}, 0);
    check("abort_val", {19'd0, w_val}, exp_wv);
    check("abort_ovf", {31'd0, w_ovf}, {31'd0, exp_wo});
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_in_idle_ignored", {31'd0, w_ready}, 1);

    // Restart from done with start and clear together; poke start mid-calc.
    run(3, 5, 5, 4, 1'b0, 1'b0);
    run(2, 1, 1, 1, 1'b1, 1'b1);
    clear_done();

    // Asynchronous reset in the middle of a run.
    i_start = 1'b1;
    i_n     = NW'(20);
    i_base  = W'(11);
    i_step  = W'(22);
    i_inc   = W'(33);
    tick();
    i_start = 1'b0;
    tick();
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    @(negedge i_clk);
    i_rst  = 1'b0;
    exp_wv = 0;
    exp_wo = 1'b0;
    exp_sv = 0;
    exp_so = 1'b0;
    tick();
    run(3, 5, 5, 4, 1'b0, 1'b0);
    clear_done();

    // Randomised runs, mixing clear, direct restart and start+clear.
    for (int it = 0; it < 40; it++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 15));
      run(n, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
          int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) clear_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
